sync_8x8_fifo: RTL and testbench

SYNC_8X8_FIFO -- requirements
Module: sync_8x8_fifo

---
 rtl/sync_8x8_fifo.sv | 92 +++++++++
 tb/tb_sync_8x8_fifo.sv | 137 +++++++++++++
 2 files changed

// File: rtl/sync_8x8_fifo.sv
// sync_8x8_fifo: single-clock FIFO with registered read data and
// combinational occupancy flags decoded from an explicit count.
// Optional macro FIFO_ERR_FLAGS_EN turns on one-cycle overrun/underrun
// pulses. Without it the two flags are constant 0. They are module outputs
// so that they are observable.
module sync_8x8_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overrun,
    output logic                  underrun
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];
    localparam logic [AW:0] CNT_AF   = CNT_FULL - 1'b1;
    localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] fifo [0:DEPTH-1];
    logic [AW-1:0]         wp;
    logic [AW-1:0]         rp;
    logic [AW:0]           count;
    logic                  wr_en;
    logic                  rd_en;

    // Acceptance uses the pre-edge flags, so a full FIFO can still be read
    // and an empty FIFO can still be written in the same cycle.
    assign wr_en = we & ~full;
    assign rd_en = re & ~empty;

    // Occupancy flags decoded straight from count.
    assign full         = (count == CNT_FULL);
    assign empty        = (count == '0);
    assign almost_full  = (count == CNT_AF);
    assign almost_empty = (count == CNT_ONE);

    // Storage has no reset. Stale words stay in place until overwritten.
    always_ff @(posedge clk) begin
        if (wr_en)
            fifo[wp] <= w_data;
    end

    // Pointers, count and read data. Pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp     <= '0;
            rp     <= '0;
            count  <= '0;
            r_data <= '0;
        end else begin
            if (wr_en)
                wp <= wp + 1'b1;
            if (rd_en) begin
                r_data <= fifo[rp];
                rp     <= rp + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // One-cycle pulses flagging a rejected write (full) or read (empty).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else begin
            overrun  <= we & full;
            underrun <= re & empty;
        end
    end
`else
    // Error reporting disabled. The flags stay at constant 0.
    assign overrun  = 1'b0;
    assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_sync_8x8_fifo.sv
// Directed bench for sync_8x8_fifo: a queue scoreboard predicts r_data and
// the flags each cycle. Internal pointers and storage are checked hierarchically.
module tb_sync_8x8_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       we;
    logic       re;
    logic [7:0] w_data;
    logic [7:0] r_data;
    logic       full, empty, almost_full, almost_empty, overrun, underrun;

    int checks   = 0;
    int failures = 0;

    logic [7:0] q[$];
    logic [7:0] m_rdata;
    int         mcount;

    sync_8x8_fifo #(.DATA_WIDTH(8), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .we(we), .re(re), .w_data(w_data),
        .r_data(r_data), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overrun(overrun), .underrun(underrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_flags();
        check("full",         32'(full),         32'(mcount == 8));
        check("empty",        32'(empty),        32'(mcount == 0));
        check("almost_full",  32'(almost_full),  32'(mcount == 7));
        check("almost_empty", 32'(almost_empty), 32'(mcount == 1));
    endtask

    // One clock cycle. The model decides acceptance from its pre-edge count.
    task automatic cycle(input logic w, input logic r, input logic [7:0] d);
        logic wacc, racc, exp_ovr, exp_udr;
        wacc = w && (mcount < 8);
        racc = r && (mcount > 0);
`ifdef FIFO_ERR_FLAGS_EN
        exp_ovr = w && (mcount == 8);
        exp_udr = r && (mcount == 0);
`else
        exp_ovr = 1'b0;
        exp_udr = 1'b0;
`endif
        @(negedge clk);
        we = w; re = r; w_data = d;
        @(posedge clk);
        #1;
        if (racc) m_rdata = q.pop_front();
        if (wacc) q.push_back(d);
        mcount = q.size();
        we = 1'b0; re = 1'b0;
        check("r_data", 32'(r_data), 32'(m_rdata));
        check_flags();
        check("overrun",  32'(overrun),  32'(exp_ovr));
        check("underrun", 32'(underrun), 32'(exp_udr));
    endtask

    logic [7:0] vec [0:7] = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D, 8'h65, 8'h12};

    initial begin
        rst = 1'b0; we = 1'b0; re = 1'b0; w_data = '0;
        m_rdata = '0; mcount = 0;

        // Reset state.
        #12;
        check("rst_r_data", 32'(r_data), 32'h0);
        check_flags();
        @(negedge clk);
        rst = 1'b1;

        // Fill with the reference vector.
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, vec[i]);
        check("wp_after_fill", 32'(dut.wp), 32'h0);
        for (int i = 0; i < 8; i++) check("fifo_fill", 32'(dut.fifo[i]), 32'(vec[i]));

        // Drain. r_data is checked inside each cycle.
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 8; i++) check("fifo_kept", 32'(dut.fifo[i]), 32'(vec[i]));

        // Hold with no traffic, then read while empty.
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 8'h3C);   // Simultaneous request while empty: only the write is accepted.
        cycle(1'b0, 1'b1, 8'h00);

        // Fill again, then write while full.
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'(8'hA0 + i));
        cycle(1'b1, 1'b0, 8'h55);
        check("count_full", 32'(dut.count), 32'h8);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b1, 1'b1, 8'h77);   // Simultaneous request while full: only the read is accepted.
        cycle(1'b1, 1'b0, 8'hA8);

        // Reduce to 4 entries, then 5 simultaneous cycles across the wrap.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, 8'(8'hC0 + i));
            check("count_rw", 32'(dut.count), 32'h4);
        end

        // Reach 5 entries, then reset between clock edges.
        cycle(1'b1, 1'b0, 8'hD5);
        check("count5", 32'(dut.count), 32'h5);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        q.delete(); mcount = 0; m_rdata = '0;
        check("async_r_data", 32'(r_data), 32'h0);
        check("async_wp", 32'(dut.wp), 32'h0);
        check("async_rp", 32'(dut.rp), 32'h0);
        check_flags();
        @(negedge clk);
        rst = 1'b1;

        // After release, the first write lands in fifo[0].
        cycle(1'b1, 1'b0, 8'hA5);
        check("post_rst_fifo0", 32'(dut.fifo[0]), 32'hA5);
        cycle(1'b0, 1'b1, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
